// File: rtl/axil_to_avmm_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_to_avmm_bridge_if
// Description : Bus bundle for the AXI4-Lite to Avalon-MM bridge. Carries the
//               AXI4-Lite channels and the Avalon-MM command/response signals.
//               Bridge-side modports: axil_slave, avmm_master.
//               Environment-side modports: axil_master, avmm_slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface axil_to_avmm_bridge_if #(
   parameter int ADDR_WIDTH       = 32,
   parameter int DATA_WIDTH       = 64,
   parameter int BURSTCOUNT_WIDTH = 7
);
   // AXI4-Lite write address / write data / write response
   logic [ADDR_WIDTH-1:0]       axil_awaddr;
   logic                        axil_awvalid;
   logic                        axil_awready;
   logic [DATA_WIDTH-1:0]       axil_wdata;
   logic [DATA_WIDTH/8-1:0]     axil_wstrb;
   logic                        axil_wvalid;
   logic                        axil_wready;
   logic [1:0]                  axil_bresp;
   logic                        axil_bvalid;
   logic                        axil_bready;
   // AXI4-Lite read address / read data
   logic [ADDR_WIDTH-1:0]       axil_araddr;
   logic                        axil_arvalid;
   logic                        axil_arready;
   logic [DATA_WIDTH-1:0]       axil_rdata;
   logic [1:0]                  axil_rresp;
   logic                        axil_rvalid;
   logic                        axil_rready;
   // Avalon-MM
   logic [ADDR_WIDTH-1:0]       avmm_address;
   logic                        avmm_read;
   logic                        avmm_write;
   logic [DATA_WIDTH-1:0]       avmm_writedata;
   logic [DATA_WIDTH/8-1:0]     avmm_byteenable;
   logic [BURSTCOUNT_WIDTH-1:0] avmm_burstcount;
   logic                        avmm_waitrequest;
   logic [DATA_WIDTH-1:0]       avmm_readdata;
   logic                        avmm_readdatavalid;
   logic [1:0]                  avmm_response;
   logic                        avmm_writeresponsevalid;

   modport axil_slave (
      input  axil_awaddr, axil_awvalid, axil_wdata, axil_wstrb, axil_wvalid,
             axil_bready, axil_araddr, axil_arvalid, axil_rready,
      output axil_awready, axil_wready, axil_bresp, axil_bvalid,
             axil_arready, axil_rdata, axil_rresp, axil_rvalid
   );

   modport axil_master (
      output axil_awaddr, axil_awvalid, axil_wdata, axil_wstrb, axil_wvalid,
             axil_bready, axil_araddr, axil_arvalid, axil_rready,
      input  axil_awready, axil_wready, axil_bresp, axil_bvalid,
             axil_arready, axil_rdata, axil_rresp, axil_rvalid
   );

   modport avmm_master (
      output avmm_address, avmm_read, avmm_write, avmm_writedata,
             avmm_byteenable, avmm_burstcount,
      input  avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
             avmm_response, avmm_writeresponsevalid
   );

   modport avmm_slave (
      input  avmm_address, avmm_read, avmm_write, avmm_writedata,
             avmm_byteenable, avmm_burstcount,
      output avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
             avmm_response, avmm_writeresponsevalid
   );
endinterface
`default_nettype wire

// File: rtl/axil_to_avmm_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axil_to_avmm_bridge
// Description : AXI4-Lite slave to Avalon-MM master bridge. One single-beat
//               transaction in flight at a time; reads and writes share the
//               AVMM port under round-robin arbitration. AVMM responses are
//               mapped onto AXI BRESP/RRESP. DATA_WIDTH must be 32 or 64.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_to_avmm_bridge #(
   parameter int ADDR_WIDTH         = 32,
   parameter int DATA_WIDTH         = 64,
   parameter int BURSTCOUNT_WIDTH   = 7,
   parameter int USE_WRITE_RESPONSE = 1
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   axil_to_avmm_bridge_if.axil_slave   s_axil,
   axil_to_avmm_bridge_if.avmm_master  m_avmm
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_CMD = 3'd1,
      WR_RSP = 3'd2,
      B_OUT  = 3'd3,
      RD_CMD = 3'd4,
      RD_RSP = 3'd5,
      R_OUT  = 3'd6
   } state_t;

   state_t                  state_q;
   logic                    init_q;      // holds all readies low until the first edge out of reset
   logic                    rr_wr_q;     // 1: write wins a tie (read was served last)
   logic                    aw_full_q;
   logic                    w_full_q;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [STRB_WIDTH-1:0]   w_strb_q;
   logic                    bvalid_q;
   logic [1:0]              bresp_q;
   logic                    rvalid_q;
   logic [1:0]              rresp_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    avmm_read_q;
   logic                    avmm_write_q;
   logic [ADDR_WIDTH-1:0]   avmm_addr_q;
   logic [DATA_WIDTH-1:0]   avmm_wdata_q;
   logic [STRB_WIDTH-1:0]   avmm_be_q;

   logic idle;
   logic wr_elig;
   logic rd_elig;
   logic pick_wr;
   logic pick_rd;
   logic awready;
   logic wready;

   // AVMM 01 is reserved and treated like 10 (SLVERR); 11 stays DECERR.
   function automatic logic [1:0] map_resp(input logic [1:0] avmm_resp);
      logic [1:0] axi_resp;
      case (avmm_resp)
         2'b00:   axi_resp = 2'b00;
         2'b11:   axi_resp = 2'b11;
         default: axi_resp = 2'b10;
      endcase
      return axi_resp;
   endfunction

   assign idle    = init_q && (state_q == IDLE);
   assign wr_elig = aw_full_q && w_full_q;
   assign rd_elig = s_axil.axil_arvalid;
   assign pick_wr = idle && wr_elig && (!rd_elig || rr_wr_q);
   assign pick_rd = idle && rd_elig && !pick_wr;
   assign awready = idle && !aw_full_q;
   assign wready  = idle && !w_full_q;

   assign s_axil.axil_awready = awready;
   assign s_axil.axil_wready  = wready;
   assign s_axil.axil_arready = pick_rd;
   assign s_axil.axil_bvalid  = bvalid_q;
   assign s_axil.axil_bresp   = bresp_q;
   assign s_axil.axil_rvalid  = rvalid_q;
   assign s_axil.axil_rresp   = rresp_q;
   assign s_axil.axil_rdata   = rdata_q;

   assign m_avmm.avmm_address    = avmm_addr_q;
   assign m_avmm.avmm_read       = avmm_read_q;
   assign m_avmm.avmm_write      = avmm_write_q;
   assign m_avmm.avmm_writedata  = avmm_wdata_q;
   assign m_avmm.avmm_byteenable = avmm_be_q;
   assign m_avmm.avmm_burstcount = BURSTCOUNT_WIDTH'(1);

   // Holding registers, arbitration pointer and the transaction state machine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         init_q       <= 1'b0;
         rr_wr_q      <= 1'b1;
         aw_full_q    <= 1'b0;
         w_full_q     <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         bvalid_q     <= 1'b0;
         bresp_q      <= 2'b00;
         rvalid_q     <= 1'b0;
         rresp_q      <= 2'b00;
         rdata_q      <= '0;
         avmm_read_q  <= 1'b0;
         avmm_write_q <= 1'b0;
         avmm_addr_q  <= '0;
         avmm_wdata_q <= '0;
         avmm_be_q    <= '0;
      end else begin
         init_q <= 1'b1;

         // AW and W land independently; a write is issued only once both are held.
         if (s_axil.axil_awvalid && awready) begin
            aw_full_q <= 1'b1;
            aw_addr_q <= s_axil.axil_awaddr;
         end
         if (s_axil.axil_wvalid && wready) begin
            w_full_q <= 1'b1;
            w_data_q <= s_axil.axil_wdata;
            w_strb_q <= s_axil.axil_wstrb;
         end

         case (state_q)
            IDLE: begin
               if (pick_wr) begin
                  state_q      <= WR_CMD;
                  avmm_write_q <= 1'b1;
                  avmm_addr_q  <= aw_addr_q;
                  avmm_wdata_q <= w_data_q;
                  avmm_be_q    <= w_strb_q;
                  aw_full_q    <= 1'b0;
                  w_full_q     <= 1'b0;
                  rr_wr_q      <= 1'b0;
               end else if (pick_rd) begin
                  state_q     <= RD_CMD;
                  avmm_read_q <= 1'b1;
                  avmm_addr_q <= s_axil.axil_araddr;
                  rr_wr_q     <= 1'b1;
               end
            end
            WR_CMD: begin
               if (!m_avmm.avmm_waitrequest) begin
                  avmm_write_q <= 1'b0;
                  if (USE_WRITE_RESPONSE != 0) begin
                     state_q <= WR_RSP;
                  end else begin
                     state_q  <= B_OUT;
                     bvalid_q <= 1'b1;
                     bresp_q  <= 2'b00;
                  end
               end
            end
            // A response coincident with command acceptance arrives in
            // WR_CMD/RD_CMD and is therefore ignored.
            WR_RSP: begin
               if (m_avmm.avmm_writeresponsevalid) begin
                  state_q  <= B_OUT;
                  bvalid_q <= 1'b1;
                  bresp_q  <= map_resp(m_avmm.avmm_response);
               end
            end
            B_OUT: begin
               if (s_axil.axil_bready) begin
                  state_q  <= IDLE;
                  bvalid_q <= 1'b0;
               end
            end
            RD_CMD: begin
               if (!m_avmm.avmm_waitrequest) begin
                  state_q     <= RD_RSP;
                  avmm_read_q <= 1'b0;
               end
            end
            RD_RSP: begin
               if (m_avmm.avmm_readdatavalid) begin
                  state_q  <= R_OUT;
                  rvalid_q <= 1'b1;
                  rdata_q  <= m_avmm.avmm_readdata;
                  rresp_q  <= map_resp(m_avmm.avmm_response);
               end
            end
            R_OUT: begin
               if (s_axil.axil_rready) begin
                  state_q  <= IDLE;
                  rvalid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire
